// File: rtl/mem_stage_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_access_if
// Brief    : EX->MEM pipeline bus, data-cache status and performance outputs
//            for the memory-access stage.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_access_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             clear;
    logic [31:0]      AluOutE;
    logic [31:0]      StoreDataE;
    logic [2:0]       Funct3E;
    logic             MemWriteE;
    logic             MemToRegE;
    logic [2:0]       RegWriteE;
    logic [4:0]       RdE;
    logic [31:0]      AluOutM;
    logic [31:0]      WDM;
    logic [3:0]       WEM;
    logic             MemToRegM;
    logic [2:0]       RegWriteM;
    logic [4:0]       RdM;
    logic             CacheMiss;
    logic             StallMem;
    logic             MisalignErr;
    logic             MissTimeout;
    logic [CNT_W-1:0] MissCount;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] AccessCount;

    modport slave (
        input  en, clear, AluOutE, StoreDataE, Funct3E, MemWriteE, MemToRegE,
               RegWriteE, RdE, CacheMiss,
        output AluOutM, WDM, WEM, MemToRegM, RegWriteM, RdM, StallMem,
               MisalignErr, MissTimeout, MissCount, StallCycles, AccessCount
    );

    modport master (
        output en, clear, AluOutE, StoreDataE, Funct3E, MemWriteE, MemToRegE,
               RegWriteE, RdE, CacheMiss,
        input  AluOutM, WDM, WEM, MemToRegM, RegWriteM, RdM, StallMem,
               MisalignErr, MissTimeout, MissCount, StallCycles, AccessCount
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_access
// Brief    : EX/MEM pipeline register with byte-lane store alignment, data-cache
//            miss tracking and saturating miss/stall/access counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_access #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_stage_access_if.slave  bus
);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MISS = 1'b1;
    localparam int         c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_TMO_MAX  = c_TW'(TIMEOUT);

    logic [1:0]       w_off;
    logic [3:0]       w_we;
    logic [31:0]      w_wd;
    logic             w_bad;
    logic             w_access;
    logic             w_stall;

    logic [31:0]      r_alu;
    logic [31:0]      r_wd;
    logic [3:0]       r_we;
    logic             r_mtr;
    logic [2:0]       r_rw;
    logic [4:0]       r_rd;
    logic             r_misalign;
    logic [0:0]       r_state;
    logic [c_TW-1:0]  r_tcnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_acc_cnt;

    assign w_off = bus.AluOutE[1:0];

    // Misaligned or unknown-width stores are squashed to a no-write.
    always_comb begin
        w_we  = 4'b0000;
        w_wd  = 32'h0;
        w_bad = 1'b0;
        if (bus.MemWriteE) begin
            case (bus.Funct3E)
                3'b000: begin
                    w_we = 4'b0001 << w_off;
                    w_wd = {24'h0, bus.StoreDataE[7:0]} << {w_off, 3'b000};
                end
                3'b001: begin
                    if (!w_off[0]) begin
                        w_we = 4'b0011 << w_off;
                        w_wd = {16'h0, bus.StoreDataE[15:0]} << {w_off, 3'b000};
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                3'b010: begin
                    if (w_off == 2'b00) begin
                        w_we = 4'b1111;
                        w_wd = bus.StoreDataE;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                default: w_bad = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu      <= 32'h0;
            r_wd       <= 32'h0;
            r_we       <= 4'b0000;
            r_mtr      <= 1'b0;
            r_rw       <= 3'b000;
            r_rd       <= 5'd0;
            r_misalign <= 1'b0;
        end else if (bus.en) begin
            if (bus.clear) begin
                r_alu <= 32'h0;
                r_wd  <= 32'h0;
                r_we  <= 4'b0000;
                r_mtr <= 1'b0;
                r_rw  <= 3'b000;
                r_rd  <= 5'd0;
            end else begin
                r_alu <= bus.AluOutE;
                r_wd  <= w_wd;
                r_we  <= w_we;
                r_mtr <= bus.MemToRegE;
                r_rw  <= bus.RegWriteE;
                r_rd  <= bus.RdE;
                if (w_bad) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign w_access = (|r_we) | r_mtr;
    assign w_stall  = w_access & bus.CacheMiss;

    // A miss is counted on entry and the access is counted on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_tcnt     <= '0;
            r_timeout  <= 1'b0;
            r_miss_cnt <= '0;
            r_acc_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_stall) begin
                        r_state <= c_ST_MISS;
                        r_tcnt  <= '0;
                        if (~&r_miss_cnt) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                    end else if (w_access && bus.en) begin
                        if (~&r_acc_cnt) begin
                            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                        end
                    end
                end
                c_ST_MISS: begin
                    if (!bus.CacheMiss) begin
                        r_state <= c_ST_IDLE;
                        if (~&r_acc_cnt) begin
                            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (r_tcnt != c_TMO_MAX) begin
                            r_tcnt <= r_tcnt + c_TW'(1);
                        end
                        if (r_tcnt >= c_TMO_LAST) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (~&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.AluOutM     = r_alu;
    assign bus.WDM         = r_wd;
    assign bus.WEM         = r_we;
    assign bus.MemToRegM   = r_mtr;
    assign bus.RegWriteM   = r_rw;
    assign bus.RdM         = r_rd;
    assign bus.StallMem    = w_stall;
    assign bus.MisalignErr = r_misalign;
    assign bus.MissTimeout = r_timeout;
    assign bus.MissCount   = r_miss_cnt;
    assign bus.StallCycles = r_stall_cnt;
    assign bus.AccessCount = r_acc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_access
// Brief    : Scoreboard bench for mem_stage_access: directed cases plus
//            random instruction streams against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_access;

    localparam int c_TO = 8;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [2:0]  f3;
        logic        mw;
        logic        mtr;
        logic [2:0]  rw;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  we;
        logic        mtr;
        logic [2:0]  rw;
        logic [4:0]  rd;
        logic        mis;
    } mitem_t;

    logic clk;
    logic rst_n;
    mem_stage_access_if #(.CNT_W(32)) bus ();

    mem_stage_access #(.CNT_W(32), .TIMEOUT(c_TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total = 0;
    int     bad   = 0;
    mitem_t sb[$];
    bit     mon_acc = 1'b0;
    bit     s_acc   = 1'b0;
    logic [31:0] s_alu = 32'h0;
    int     m_miss = 0, m_stall = 0, m_acc = 0;
    bit     m_mis = 1'b0, m_to = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [2:0] f3, input logic mw, input logic mtr,
                                  input logic [2:0] rw, input logic [4:0] rd);
        instr_t i;
        i.alu = alu; i.sd = sd; i.f3 = f3; i.mw = mw; i.mtr = mtr; i.rw = rw; i.rd = rd;
        return i;
    endfunction

    // Reference: byte offset picks the lane; width must divide the offset.
    function automatic mitem_t model_m(input instr_t i, output bit badst);
        mitem_t r;
        int o;
        o = int'(i.alu % 4);
        r.alu = i.alu; r.mtr = i.mtr; r.rw = i.rw; r.rd = i.rd;
        r.we = 4'h0; r.wd = 32'h0; r.mis = 1'b0;
        badst = 1'b0;
        if (i.mw) begin
            if (i.f3 == 3'd0) begin
                r.we = 4'(1 << o);
                r.wd = (i.sd & 32'hFF) << (8 * o);
            end else if (i.f3 == 3'd1 && (o % 2) == 0) begin
                r.we = 4'(3 << o);
                r.wd = (i.sd & 32'hFFFF) << (8 * o);
            end else if (i.f3 == 3'd2 && o == 0) begin
                r.we = 4'hF;
                r.wd = i.sd;
            end else begin
                badst = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic chk_cnt();
        chk("miss_count",   bus.MissCount,   32'(m_miss));
        chk("stall_cycles", bus.StallCycles, 32'(m_stall));
        chk("access_count", bus.AccessCount, 32'(m_acc));
        chk("miss_timeout", {31'h0, bus.MissTimeout}, {31'h0, m_to});
    endtask

    // nmiss: miss length for the instruction already in MEM; nhold: idle en=0 cycles.
    task automatic issue(input instr_t ins, input int nmiss, input int nhold, input bit clr);
        mitem_t e;
        bit     bs;
        @(negedge clk);
        chk_cnt();
        bus.AluOutE = ins.alu; bus.StoreDataE = ins.sd; bus.Funct3E = ins.f3;
        bus.MemWriteE = ins.mw; bus.MemToRegE = ins.mtr; bus.RegWriteE = ins.rw;
        bus.RdE = ins.rd;
        if (s_acc && nmiss > 0) begin
            m_miss++;
            m_stall += nmiss;
            if (nmiss - 1 >= c_TO) m_to = 1'b1;
            for (int k = 0; k < nmiss; k++) begin
                bus.CacheMiss = 1'b1; bus.en = 1'b0; bus.clear = 1'($urandom % 2);
                #3;
                chk("hold_alu", bus.AluOutM, s_alu);
                @(negedge clk);
            end
        end else begin
            for (int k = 0; k < nhold; k++) begin
                bus.CacheMiss = 1'b0; bus.en = 1'b0; bus.clear = 1'($urandom % 2);
                @(negedge clk);
            end
        end
        bus.CacheMiss = 1'b0; bus.clear = clr; bus.en = 1'b1;
        if (clr) begin
            e.alu = 32'h0; e.wd = 32'h0; e.we = 4'h0; e.mtr = 1'b0; e.rw = 3'h0; e.rd = 5'h0;
        end else begin
            e = model_m(ins, bs);
            if (bs) m_mis = 1'b1;
        end
        e.mis = m_mis;
        sb.push_back(e);
        if (s_acc) m_acc++;
        s_acc = (e.we != 4'h0) || e.mtr;
        s_alu = e.alu;
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.clear = 1'b0;
    endtask

    // Monitor: checks stall every cycle and retires one item per enabled edge.
    initial begin
        bit     en_s;
        mitem_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("stall_mem", {31'h0, bus.StallMem}, {31'h0, mon_acc & bus.CacheMiss});
            end
            en_s = bus.en & rst_n;
            @(posedge clk);
            #1;
            if (en_s) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard_empty actual=capture required=none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("m_alu", bus.AluOutM, e.alu);
                    chk("m_wd",  bus.WDM, e.wd);
                    chk("m_we",  {28'h0, bus.WEM}, {28'h0, e.we});
                    chk("m_mtr", {31'h0, bus.MemToRegM}, {31'h0, e.mtr});
                    chk("m_rw",  {29'h0, bus.RegWriteM}, {29'h0, e.rw});
                    chk("m_rd",  {27'h0, bus.RdM}, {27'h0, e.rd});
                    chk("m_mis", {31'h0, bus.MisalignErr}, {31'h0, e.mis});
                    mon_acc = (e.we != 4'h0) || e.mtr;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu"}, bus.AluOutM, 32'h0);
        chk({tag, "_wd"},  bus.WDM, 32'h0);
        chk({tag, "_we"},  {28'h0, bus.WEM}, 32'h0);
        chk({tag, "_ctl"}, {23'h0, bus.MemToRegM, bus.RegWriteM, bus.RdM}, 32'h0);
        chk({tag, "_flags"}, {29'h0, bus.StallMem, bus.MisalignErr, bus.MissTimeout}, 32'h0);
        chk({tag, "_cnt"}, bus.MissCount | bus.StallCycles | bus.AccessCount, 32'h0);
    endtask

    initial begin
        instr_t nop;
        instr_t ri;
        int     kind;
        int     nm;
        nop = mk(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 3'd0, 5'd0);
        rst_n = 1'b0;
        bus.en = 1'b0; bus.clear = 1'b0; bus.CacheMiss = 1'b0;
        bus.AluOutE = 32'h0; bus.StoreDataE = 32'h0; bus.Funct3E = 3'd0;
        bus.MemWriteE = 1'b0; bus.MemToRegE = 1'b0; bus.RegWriteE = 3'd0; bus.RdE = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(mk(32'h1002, 32'h12AB, 3'd0, 1'b1, 1'b0, 3'd0, 5'd0), 0, 0, 1'b0);
        chk("sb_we", {28'h0, bus.WEM}, 32'h4);
        chk("sb_wd", bus.WDM, 32'h00AB0000);
        chk("sb_alu", bus.AluOutM, 32'h1002);
        issue(mk(32'h1002, 32'hBEEF, 3'd1, 1'b1, 1'b0, 3'd0, 5'd0), 0, 0, 1'b0);
        chk("sh_we", {28'h0, bus.WEM}, 32'hC);
        chk("sh_wd", bus.WDM, 32'hBEEF0000);
        issue(mk(32'h1001, 32'h5555, 3'd2, 1'b1, 1'b0, 3'd0, 5'd0), 0, 0, 1'b0);
        chk("sw_mis_we", {28'h0, bus.WEM}, 32'h0);
        chk("sw_mis_flag", {31'h0, bus.MisalignErr}, 32'h1);
        issue(mk(32'h2000, 32'hCAFEF00D, 3'd2, 1'b1, 1'b0, 3'd0, 5'd0), 0, 0, 1'b0);
        @(negedge clk);
        bus.clear = 1'b1; bus.en = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_noen_alu", bus.AluOutM, 32'h2000);
        chk("clr_noen_we", {28'h0, bus.WEM}, 32'hF);
        bus.clear = 1'b0;
        issue(mk(32'h2004, 32'h1, 3'd2, 1'b1, 1'b0, 3'd1, 5'd3), 0, 0, 1'b1);
        chk("clr_alu", bus.AluOutM, 32'h0);
        chk("clr_we", {28'h0, bus.WEM}, 32'h0);
        chk("mis_sticky", {31'h0, bus.MisalignErr}, 32'h1);

        issue(mk(32'h3000, 32'h0, 3'd2, 1'b0, 1'b1, 3'd2, 5'd7), 0, 0, 1'b0);
        issue(nop, 5, 0, 1'b0);
        chk("load_miss_count", bus.MissCount, 32'd1);
        chk("load_stall_cycles", bus.StallCycles, 32'd5);
        issue(mk(32'h3004, 32'h0, 3'd2, 1'b0, 1'b1, 3'd2, 5'd8), 0, 0, 1'b0);
        issue(nop, 6, 0, 1'b0);
        chk("short_miss_no_timeout", {31'h0, bus.MissTimeout}, 32'h0);
        issue(mk(32'h3008, 32'h0, 3'd2, 1'b0, 1'b1, 3'd2, 5'd9), 0, 0, 1'b0);
        issue(nop, 12, 0, 1'b0);
        chk("long_miss_timeout", {31'h0, bus.MissTimeout}, 32'h1);

        // Reset asserted in the third cycle of a miss.
        issue(mk(32'h4000, 32'h0, 3'd2, 1'b0, 1'b1, 3'd2, 5'd1), 0, 0, 1'b0);
        @(negedge clk);
        chk_cnt();
        bus.AluOutE = 32'h0; bus.MemWriteE = 1'b0; bus.MemToRegE = 1'b0;
        bus.CacheMiss = 1'b1; bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_mid_miss");
        sb.delete();
        mon_acc = 1'b0; s_acc = 1'b0; s_alu = 32'h0;
        m_miss = 0; m_stall = 0; m_acc = 0; m_mis = 1'b0; m_to = 1'b0;
        @(negedge clk);
        bus.CacheMiss = 1'b0;
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom % 4);
            ri = mk($urandom, $urandom, 3'($urandom % 3), 1'b0, 1'b0,
                    3'($urandom), 5'($urandom));
            if (kind == 0) begin
                ri.mtr = 1'b1;
            end else if (kind >= 2) begin
                ri.mw = 1'b1;
                if ($urandom % 8 == 0) ri.f3 = 3'(3 + $urandom % 5);
            end
            nm = (s_acc && ($urandom % 3 == 0)) ? int'(1 + $urandom % 6) : 0;
            issue(ri, nm, ($urandom % 5 == 0) ? int'(1 + $urandom % 3) : 0,
                  ($urandom % 10 == 0));
        end
        issue(nop, 0, 0, 1'b0);
        @(negedge clk);
        chk_cnt();
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_left actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
